// File: rtl/rmii_pkg.sv
// Shared types and constants for the N-channel RMII receive mux.
// Latency: none, types and constants only.
// Backpressure: none, types and constants only.
package rmii_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        DATA,
        DROP
    } rx_state_e;

    typedef struct packed {
        logic       last;
        logic       err;
        logic [7:0] data;
    } rx_entry_t;

    localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
    localparam logic [1:0] SFD_DIBIT      = 2'b11;

endpackage

// File: rtl/rmii_rx_mux_if.sv
// Merged byte stream out of the RMII receive mux, tagged with channel, last and err.
// Latency: none, wires only.
// Backpressure: valid/ready; the master holds data and chan stable while valid && !ready.
interface rmii_rx_mux_if #(
    parameter int CH_W = 1
);
    logic            m_valid;
    logic            m_ready;
    logic [7:0]      m_data;
    logic            m_last;
    logic            m_err;
    logic [CH_W-1:0] m_chan;

    modport master (output m_valid, output m_data, output m_last, output m_err, output m_chan,
                    input  m_ready);
    modport slave  (input  m_valid, input  m_data, input  m_last, input  m_err, input  m_chan,
                    output m_ready);
endinterface

// File: rtl/rmii_fifo.sv
// Generic synchronous FIFO with combinational head and occupancy count.
// Latency: an entry pushed at edge N is at the head after edge N.
// Backpressure: push ignored when full, pop ignored when empty; push and pop may coincide.
module rmii_fifo #(
    parameter  int W     = 10,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         empty,
    output logic [AW:0]  count
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    // Pointer and count update; full/empty guards keep the pointers consistent.
    always_comb begin
        do_push = push && (cnt_q != (AW+1)'(DEPTH));
        do_pop  = pop && (cnt_q != '0);
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        if (do_push) begin
            mem_d[wr_q] = push_dat;
            wr_d        = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // Pointer state with synchronous reset, which empties the FIFO.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage carries no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_dat = mem_q[rd_q];
    assign empty    = (cnt_q == '0);
    assign count    = cnt_q;
endmodule

// File: rtl/rmii_rx_chan.sv
// One RMII receive channel: preamble/SFD strip, dibit packing, stage register, FIFO, truncation.
// Latency: a byte reaches the FIFO when the next byte completes, or at frame end if it is the last.
// Backpressure: none towards the PHY; on a full FIFO the frame is closed with err and the rest dropped (RMII_RX_ER_FLAG_EN adds rx_er flagging).
module rmii_rx_chan
    import rmii_pkg::*;
#(
    parameter  int FIFO_DEPTH = 16,
    localparam int AW         = $clog2(FIFO_DEPTH)
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       crs_dv,
    input  logic [1:0] rx_d,
    input  logic       rx_er,
    input  logic       pop,
    output rx_entry_t  head,
    output logic       empty,
    output logic       ovf_pulse
);
    rx_state_e   state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [5:0]  sh_q, sh_d;
    logic        stg_vld_q, stg_vld_d;
    logic [7:0]  stg_q, stg_d;
    logic        err_q, err_d;
    logic        ovf_q, ovf_d;
    logic        err_hit;
    logic        push_req;
    rx_entry_t   push_ent;
    logic        fifo_push;
    rx_entry_t   fifo_dat;
    logic [AW:0] fifo_cnt;

`ifdef RMII_RX_ER_FLAG_EN
    assign err_hit = (state_q == DATA) && rx_er;
`else
    logic unused_rx_er;
    assign err_hit      = 1'b0;
    assign unused_rx_er = rx_er;
`endif

    // Frame FSM and packer; the staged byte is held back until we know whether it is the last one.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        stg_vld_d = stg_vld_q;
        stg_d     = stg_q;
        err_d     = err_q;
        ovf_d     = 1'b0;
        push_req  = 1'b0;
        push_ent  = '0;
        fifo_push = 1'b0;
        fifo_dat  = '0;
        case (state_q)
            IDLE: begin
                if (crs_dv && rx_d == PREAMBLE_DIBIT) state_d = PRE;
            end
            PRE: begin
                if (!crs_dv) begin
                    state_d = IDLE;
                end else if (rx_d == SFD_DIBIT) begin
                    state_d   = DATA;
                    cnt_d     = 2'd0;
                    stg_vld_d = 1'b0;
                    err_d     = 1'b0;
                end else if (rx_d != PREAMBLE_DIBIT) begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (!crs_dv) begin
                    // Frame end: a partial byte in sh_q is simply abandoned.
                    state_d   = IDLE;
                    stg_vld_d = 1'b0;
                    if (stg_vld_q) begin
                        push_req = 1'b1;
                        push_ent = '{last: 1'b1, err: err_q | err_hit, data: stg_q};
                    end
                end else begin
                    err_d = err_q | err_hit;
                    cnt_d = cnt_q + 1'b1;
                    case (cnt_q)
                        2'd0:    sh_d[1:0] = rx_d;
                        2'd1:    sh_d[3:2] = rx_d;
                        2'd2:    sh_d[5:4] = rx_d;
                        default: begin
                            stg_d     = {rx_d, sh_q};
                            stg_vld_d = 1'b1;
                            if (stg_vld_q) begin
                                push_req = 1'b1;
                                push_ent = '{last: 1'b0, err: 1'b0, data: stg_q};
                            end
                        end
                    endcase
                end
            end
            DROP: begin
                if (!crs_dv) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The final slot is reserved for a closing entry, so a non-last push there truncates the frame.
        if (push_req) begin
            fifo_push = 1'b1;
            fifo_dat  = push_ent;
            if (!push_ent.last && int'(fifo_cnt) >= FIFO_DEPTH - 1) begin
                fifo_dat.last = 1'b1;
                fifo_dat.err  = 1'b1;
                ovf_d         = 1'b1;
                state_d       = DROP;
                stg_vld_d     = 1'b0;
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            sh_q      <= '0;
            stg_vld_q <= 1'b0;
            stg_q     <= '0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            stg_vld_q <= stg_vld_d;
            stg_q     <= stg_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
        end
    end

    rmii_fifo #(
        .W     ($bits(rx_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (fifo_push),
        .push_dat (fifo_dat),
        .pop      (pop),
        .head_dat (head),
        .empty    (empty),
        .count    (fifo_cnt)
    );

    assign ovf_pulse = ovf_q;
endmodule

// File: rtl/rmii_rx_mux.sv
// N-channel RMII receive front end merged onto one tagged byte stream by a frame-atomic round robin.
// Latency: head bytes appear combinationally; one idle cycle between frames for re-arbitration.
// Backpressure: m_ready low holds the granted FIFO head; channels buffer, then truncate on full (RMII_RX_ER_FLAG_EN adds rx_er flagging).
module rmii_rx_mux
    import rmii_pkg::*;
#(
    parameter  int N_CH       = 2,
    parameter  int FIFO_DEPTH = 16,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [N_CH-1:0]   crs_dv,
    input  logic [2*N_CH-1:0] rx_d,
    input  logic [N_CH-1:0]   rx_er,
    rmii_rx_mux_if.master     m,
    output logic [N_CH-1:0]   ovf_pulse
);
    rx_entry_t       heads [N_CH];
    rx_entry_t       head_sel;
    logic [N_CH-1:0] empty;
    logic [N_CH-1:0] pop;
    logic            vld;
    logic            lock_q, lock_d;
    logic [CH_W-1:0] grant_q, grant_d;
    logic [CH_W-1:0] ptr_q, ptr_d;
    logic [CH_W-1:0] cand;
    logic            found;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        rmii_rx_chan #(
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_chan (
            .clk       (clk),
            .resetn    (resetn),
            .crs_dv    (crs_dv[c]),
            .rx_d      (rx_d[2*c +: 2]),
            .rx_er     (rx_er[c]),
            .pop       (pop[c]),
            .head      (heads[c]),
            .empty     (empty[c]),
            .ovf_pulse (ovf_pulse[c])
        );
    end

    // Output mux: only a locked grant with a non-empty FIFO presents a byte.
    always_comb begin
        head_sel    = heads[grant_q];
        vld         = lock_q && !empty[grant_q];
        m.m_valid   = vld;
        m.m_data    = vld ? head_sel.data : 8'h00;
        m.m_last    = vld && head_sel.last;
        m.m_err     = vld && head_sel.last && head_sel.err;
        m.m_chan    = grant_q;
        pop         = '0;
        if (vld && m.m_ready) pop[grant_q] = 1'b1;
    end

    // Round robin: ptr_q is where the next search starts (one past the last grant; ch0 after reset).
    always_comb begin
        grant_d = grant_q;
        lock_d  = lock_q;
        ptr_d   = ptr_q;
        found   = 1'b0;
        cand    = '0;
        if (!lock_q) begin
            for (int i = 0; i < N_CH; i++) begin
                cand = CH_W'((int'(ptr_q) + i) % N_CH);
                if (!found && !empty[cand]) begin
                    found   = 1'b1;
                    grant_d = cand;
                    lock_d  = 1'b1;
                    ptr_d   = (int'(cand) == N_CH - 1) ? '0 : cand + 1'b1;
                end
            end
        end else if (vld && m.m_ready && head_sel.last) begin
            lock_d = 1'b0;
        end
    end

    // Arbiter state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_q  <= 1'b0;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            lock_q  <= lock_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end
endmodule

// File: tb/tb_rmii_rx_mux.sv
// Scoreboard bench for rmii_rx_mux: directed RMII frames, expected bytes queued at issue time.
// Latency: n/a.
// Backpressure: m_ready driven by the stimulus process to exercise buffering and truncation.
module tb_rmii_rx_mux;
    localparam int N_CH  = 2;
    localparam int DEPTH = 16;
    localparam int CH_W  = 1;

    typedef logic [CH_W+9:0] exp_t;
    typedef logic [7:0]      byte_q_t[$];

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic              ch_crs [N_CH];
    logic [1:0]        ch_d   [N_CH];
    logic              ch_er  [N_CH];
    logic [N_CH-1:0]   crs_dv, rx_er, ovf_pulse;
    logic [2*N_CH-1:0] rx_d;

    for (genvar c = 0; c < N_CH; c++) begin : g_drv
        assign crs_dv[c]       = ch_crs[c];
        assign rx_d[2*c +: 2]  = ch_d[c];
        assign rx_er[c]        = ch_er[c];
    end

    rmii_rx_mux_if #(.CH_W(CH_W)) mif ();

    rmii_rx_mux #(.N_CH(N_CH), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .crs_dv    (crs_dv),
        .rx_d      (rx_d),
        .rx_er     (rx_er),
        .m         (mif),
        .ovf_pulse (ovf_pulse)
    );

    exp_t exp_q[$];
    exp_t e;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   ovf_cnt [N_CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Monitor: every accepted byte must match the head of the expected queue.
    always @(negedge clk) begin
        if (resetn) begin
            for (int c = 0; c < N_CH; c++) if (ovf_pulse[c]) ovf_cnt[c]++;
            if (mif.m_valid && mif.m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {mif.m_chan, mif.m_last, mif.m_err, mif.m_data}, 32'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer", {mif.m_chan, mif.m_last, mif.m_err, mif.m_data}, 32'(e));
                end
            end
        end
    end

    task automatic drive(input int ch, input logic c, input logic [1:0] d, input logic er);
        ch_crs[ch] = c;
        ch_d[ch]   = d;
        ch_er[ch]  = er;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int ch, input byte_q_t bytes, input int extra, input int er_at);
        logic [7:0] cur;
        for (int i = 0; i < 31; i++) drive(ch, 1'b1, 2'b01, 1'b0);
        drive(ch, 1'b1, 2'b11, 1'b0);
        for (int b = 0; b < bytes.size(); b++) begin
            cur = bytes[b];
            for (int k = 0; k < 4; k++) drive(ch, 1'b1, cur[2*k +: 2], (b*4 + k) == er_at);
        end
        for (int i = 0; i < extra; i++) drive(ch, 1'b1, 2'b10, 1'b0);
        for (int i = 0; i < 4; i++) drive(ch, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic expect_frame(input int ch, input byte_q_t bytes, input logic err);
        for (int b = 0; b < bytes.size(); b++) begin
            if (b == bytes.size() - 1) exp_q.push_back({CH_W'(ch), 1'b1, err, bytes[b]});
            else                      exp_q.push_back({CH_W'(ch), 1'b0, 1'b0, bytes[b]});
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        byte_q_t q0, q1, q3, q6, qa;
        int      base;
        logic    er_exp;
        for (int c = 0; c < N_CH; c++) begin
            ch_crs[c] = 1'b0; ch_d[c] = 2'b00; ch_er[c] = 1'b0; ovf_cnt[c] = 0;
        end
        mif.m_ready = 1'b1;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("rst_valid", mif.m_valid, 0);
        check("rst_last",  mif.m_last,  0);
        check("rst_err",   mif.m_err,   0);
        check("rst_chan",  mif.m_chan,  0);
        check("rst_data",  mif.m_data,  0);
        check("rst_ovf",   ovf_pulse,   0);
        @(posedge clk);
        #1;

        // Simultaneous frames: ch0 wins from reset, ch1 follows whole.
        q0 = '{8'h11, 8'h22, 8'h33};
        q1 = '{8'hC1, 8'hC2, 8'hC3};
        expect_frame(0, q0, 1'b0);
        expect_frame(1, q1, 1'b0);
        fork
            send_frame(0, q0, 0, -1);
            send_frame(1, q1, 0, -1);
        join
        wait_drain("t2_drain");

        // Basic frame on ch0.
        q0 = '{8'h55, 8'hAA, 8'h0F};
        expect_frame(0, q0, 1'b0);
        send_frame(0, q0, 0, -1);
        wait_drain("t1_drain");

        // Trailing dibit after the third byte is discarded.
        q0 = '{8'h3C, 8'h81, 8'hE7};
        expect_frame(0, q0, 1'b0);
        send_frame(0, q0, 1, -1);
        wait_drain("t4_drain");

        // rx_er pulse on the third dibit of the second byte.
`ifdef RMII_RX_ER_FLAG_EN
        er_exp = 1'b1;
`else
        er_exp = 1'b0;
`endif
        q1 = '{8'h12, 8'h34, 8'h56, 8'h78};
        expect_frame(1, q1, er_exp);
        send_frame(1, q1, 0, 6);
        wait_drain("t5_drain");

        // 40-byte frame into a stalled sink: 15 clean entries, then byte 16 closes with err.
        q3 = {};
        for (int i = 0; i < 40; i++) q3.push_back(8'(i*7 + 1));
        for (int i = 0; i < 15; i++) exp_q.push_back({CH_W'(1), 1'b0, 1'b0, q3[i]});
        exp_q.push_back({CH_W'(1), 1'b1, 1'b1, q3[15]});
        mif.m_ready = 1'b0;
        base = ovf_cnt[1];
        send_frame(1, q3, 0, -1);
        check("t3_ovf_pulses", ovf_cnt[1] - base, 1);
        check("t3_queued", exp_q.size(), 16);
        mif.m_ready = 1'b1;
        wait_drain("t3_drain");

        // Reset in the middle of a buffered frame; bytes avoid the 01 dibit so nothing restarts.
        qa = '{8'h00, 8'hAA, 8'h00, 8'hAA, 8'h00, 8'hAA};
        mif.m_ready = 1'b0;
        fork
            send_frame(0, qa, 0, -1);
            begin
                repeat (50) @(posedge clk);
                @(negedge clk);
                check("t6_buffered", mif.m_valid, 1);
                resetn = 1'b0;
                @(negedge clk);
                resetn = 1'b1;
                check("t6_valid_after_rst", mif.m_valid, 0);
            end
        join
        check("t6_ovf_none", ovf_pulse, 0);
        mif.m_ready = 1'b1;
        q6 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        expect_frame(0, q6, 1'b0);
        send_frame(0, q6, 0, -1);
        wait_drain("t6_drain");

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
